ecc_scrub_mem: RTL and testbench
================================

// Module: ecc_scrub_mem
// PURPOSE
//  Parametrised SECDED-protected single-port memory with a background scrubber.
//  - Write path: encodes data into a Hamming+overall-parity codeword.
//  - Read path: decodes, corrects single errors, flags double errors.
//  - Corrected codewords are written back to the array; a scrubber walks all
//    addresses during idle cycles.
//  - Successor to the fixed 32-bit encode/decode/channel pair; sits between a
//    core load/store port and on-chip SRAM.
// PARAMETERS
//  DATA_W          32    data bits per word (4..64)
//  DEPTH           64    words in the array (power of two, >=2)
//  SCRUB_INTERVAL  1024  idle cycles between scrub accesses (>=2)
//  (derived) P = smallest int with 2^P >= DATA_W+P+1; ECC_W = P+1; CW_W = DATA_W+ECC_W
// PORTS
//  clk             in   1             clock, all logic on rising edge
//  rst_l           in   1             synchronous active-low reset
//  req_valid       in   1             request present
//  req_ready       out  1             request accepted when valid&&ready
//  req_we          in   1             1=write, 0=read
//  req_addr        in   $clog2(DEPTH) word address
//  req_wdata       in   DATA_W        write data
//  inj_en          in   1             apply inj_mask on user writes
//  inj_mask        in   CW_W          bits XORed into stored codeword {ecc,data}
//  scrub_en        in   1             enable background scrubbing
//  rsp_valid       out  1             read response strobe
//  rsp_rdata       out  DATA_W        corrected (or raw, on double error) data
//  rsp_single_err  out  1             response had a corrected single error
//  rsp_double_err  out  1             response had an uncorrectable error
//  sec_count       out  16            single errors seen (user+scrub), saturating
//  ded_count       out  16            double errors seen (user+scrub), saturating
//  ded_addr        out  $clog2(DEPTH) address of most recent double error
// BEHAVIOUR
//  Reset (rst_l=0 at edge)
//  - All outputs and counters go to 0; FSM goes to INIT; scrub pointer and
//    interval counter go to 0.
//  - Reset mid-operation aborts any pending writeback and restarts INIT.
//  Encoding
//  - Data bits fill the non-power-of-two codeword positions 1..DATA_W+P in
//    ascending order.
//  - Check bit i = XOR of data bits whose position has bit i set.
//  - ecc[P] = XOR of all data and check bits. Stored word = {ecc, data}.
//  Decoding
//  - syndrome = recomputed XOR stored check bits; overall parity is recomputed.
//  - syn=0, par ok: clean.
//  - par bad: single error; flip position syn. syn=0 or syn>DATA_W+P means the
//    error is in ecc[P] or the check bits, and the data is unchanged.
//  - syn!=0, par ok: double error.
//  FSM
//  - INIT: writes the codeword of 0 to addresses 0..DEPTH-1, one per cycle,
//    with req_ready=0. Goes to IDLE after DEPTH-1.
//  - IDLE: accepts requests.
//  - SCRUB_RD: one cycle. Reads scrub_ptr while req_ready=0.
//  - SCRUB_CHK: one cycle. Decodes and updates counters. Writes back on single
//    error. Increments scrub_ptr, wrapping DEPTH-1 to 0. Returns to IDLE.
//  Request handling
//  - Write accepted at cycle N: array updated at edge N. No response.
//  - Read accepted at cycle N: array read registered at N+1. rsp_valid=1 with
//    data and flags in cycle N+2 (latency 2). Back-to-back reads are accepted
//    every cycle.
//  - Single error on read: the corrected codeword is written back in cycle N+2
//    and req_ready=0 in that cycle.
//  - Writeback is suppressed if a user write to the same address was accepted
//    in cycle N+1.
//  - Double error: rsp_rdata = raw stored data. No writeback. ded_addr is
//    updated.
//  - rsp_* hold 0 when rsp_valid=0.
//  Scrub
//  - Interval counter increments in IDLE cycles while scrub_en=1 and no request
//    is accepted. The counter clears when scrub_en=0.
//  - At SCRUB_INTERVAL-1 with req_valid=0 and no read in flight: go to
//    SCRUB_RD and clear the counter.
//  - If req_valid=1, the user request wins and the scrub waits.
//  Injection and counters
//  - Injection applies only to user writes; writebacks and INIT never inject.
//  - If the single and double error counters must both increment in one cycle
//    (user read and scrub check), each counter increments by the number of
//    events. Counters saturate at 16'hFFFF.
// TESTING
//  T1 Reset: rst_l=0 then 1 -> req_ready=0 for exactly DEPTH cycles. A read of
//     addr 5 then returns 0 with no error flags.
//  T2 Clean: write 32'hDEADBEEF to addr 3, read addr 3 -> rsp_valid 2 cycles
//     after accept, rdata=DEADBEEF, flags 0.
//  T3 SEC: write 32'h12345678 with inj_en=1, inj_mask=1<<7 -> read gives
//     12345678, single_err=1, sec_count=1. Second read is clean.
//  T4 DED: inj_mask=(1<<0)|(1<<38), data 32'hA5A5A5A5 at addr 9 -> read gives
//     double_err=1, ded_count=1, ded_addr=9, and the error persists.
//  T5 Scrub: single error at addr 0, SCRUB_INTERVAL=4, scrub_en=1, idle ->
//     sec_count=1 within 8 cycles. A later read of addr 0 is clean.
//  T6 Hazard: read addr 2 (single error) then write 32'h0 to addr 2 next cycle
//     -> no writeback; later read returns 0, clean.

Source files
------------

// File: rtl/ecc_scrub_mem.sv
// ---------------------------------------------------------------------------
// ecc_scrub_mem
//
// SECDED-protected single-port word memory with a background scrubber.
// Every stored word is a Hamming codeword extended with an overall parity bit,
// laid out as {ecc, data}. Reads correct single-bit errors and flag
// double-bit errors. Corrected words are written back to the array. While the
// port is idle, a scrubber periodically reads one address, corrects it, and
// moves on to the next address.
//
// The array is never read and written in the same cycle. Every cycle is
// exactly one of: INIT write, user read, user write, writeback, scrub read,
// or scrub writeback. This lets the array map onto a true single-port SRAM.
//
// Parameters
//   DATA_W          data bits per word (4..64)
//   DEPTH           words in the array (power of two, >= 2)
//   SCRUB_INTERVAL  idle cycles between scrub accesses (>= 2)
//
// Ports
//   clk             clock, all logic on the rising edge
//   rst_l           synchronous active-low reset
//   req_valid       request present
//   req_ready       request accepted when req_valid && req_ready
//   req_we          1 = write, 0 = read
//   req_addr        word address
//   req_wdata       write data
//   inj_en          XOR inj_mask into the codeword of a user write
//   inj_mask        error-injection mask over the stored {ecc, data}
//   scrub_en        enable background scrubbing
//   rsp_valid       read response strobe (two cycles after accept)
//   rsp_rdata       corrected data, or raw stored data on a double error
//   rsp_single_err  response carried a corrected single error
//   rsp_double_err  response carried an uncorrectable error
//   sec_count       saturating count of single errors (user + scrub)
//   ded_count       saturating count of double errors (user + scrub)
//   ded_addr        address of the most recent double error
// ---------------------------------------------------------------------------
module ecc_scrub_mem #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 64,
  parameter int SCRUB_INTERVAL = 1024,
  // Smallest P with 2^P >= DATA_W + P + 1, for DATA_W in 4..64.
  localparam int P     = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 :
                         (DATA_W <= 57) ? 6 : 7,
  localparam int ECC_W = P + 1,
  localparam int CW_W  = DATA_W + ECC_W,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              inj_en,
  input  logic [CW_W-1:0]   inj_mask,
  input  logic              scrub_en,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_single_err,
  output logic              rsp_double_err,
  output logic [15:0]       sec_count,
  output logic [15:0]       ded_count,
  output logic [AW-1:0]     ded_addr
);

  localparam int CNT_W = $clog2(SCRUB_INTERVAL);
  localparam logic [CNT_W-1:0] SCRUB_LAST = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [AW-1:0]    ADDR_LAST  = AW'(DEPTH - 1);

  localparam logic [1:0] S_INIT      = 2'd0;
  localparam logic [1:0] S_IDLE      = 2'd1;
  localparam logic [1:0] S_SCRUB_RD  = 2'd2;
  localparam logic [1:0] S_SCRUB_CHK = 2'd3;

  // -------------------------------------------------------------------------
  // Codeword helpers
  // -------------------------------------------------------------------------
  typedef logic [DATA_W-1:0][P-1:0] pos_tbl_t;

  typedef struct packed {
    logic              sec;
    logic              ded;
    logic [DATA_W-1:0] data;
    logic [CW_W-1:0]   fixed_cw;
  } dec_t;

  // Hamming position (1-based) of each data bit. Data bits take the
  // non-power-of-two positions in ascending order.
  function automatic pos_tbl_t f_dpos();
    pos_tbl_t t;
    int       pos;
    t   = '0;
    pos = 1;
    for (int k = 0; k < DATA_W; k++) begin
      while ((pos & (pos - 1)) == 0) pos++;
      t[k] = pos[P-1:0];
      pos++;
    end
    return t;
  endfunction

  localparam pos_tbl_t DPOS = f_dpos();

  // Check bit i covers every data bit whose position has bit i set.
  function automatic logic [P-1:0] f_chk(input logic [DATA_W-1:0] d);
    logic [P-1:0] c;
    c = '0;
    for (int i = 0; i < P; i++) begin
      for (int k = 0; k < DATA_W; k++) begin
        c[i] = c[i] ^ (d[k] & DPOS[k][i]);
      end
    end
    return c;
  endfunction

  // The top ecc bit makes the XOR of the whole codeword zero.
  function automatic logic [CW_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [P-1:0] c;
    c = f_chk(d);
    return {^{d, c}, c, d};
  endfunction

  // A single error always toggles overall parity. If the syndrome does not
  // land on a data position, the flipped bit was a check bit or the parity
  // bit, and the data is already correct. The corrected codeword is rebuilt
  // from the corrected data, so it is clean whichever bit was hit.
  function automatic dec_t f_decode(input logic [CW_W-1:0] cw);
    dec_t              r;
    logic [DATA_W-1:0] d;
    logic [P-1:0]      syn;
    logic              par_bad;
    d       = cw[DATA_W-1:0];
    syn     = f_chk(d) ^ cw[DATA_W +: P];
    par_bad = ^cw;
    if (par_bad) begin
      for (int k = 0; k < DATA_W; k++) begin
        if (syn == DPOS[k]) d[k] = ~d[k];
      end
    end
    r.sec      = par_bad;
    r.ded      = !par_bad && (syn != '0);
    r.data     = d;
    r.fixed_cw = f_encode(d);
    return r;
  endfunction

  function automatic logic [15:0] f_sat_add(input logic [15:0] c,
                                            input logic [1:0]  inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [CW_W-1:0]   r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [AW-1:0]     r_ptr;        // INIT fill address, then scrub address
  logic [CNT_W-1:0]  r_scrub_cnt;

  logic              r_rd_vld;     // user read has its word in r_rd_cw
  logic [AW-1:0]     r_rd_addr;
  logic [CW_W-1:0]   r_rd_cw;      // shared by user reads and scrub reads

  logic              r_wb_pend;
  logic [AW-1:0]     r_wb_addr;
  logic [CW_W-1:0]   r_wb_cw;

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_sec;
  logic              r_rsp_ded;
  logic [15:0]       r_sec_cnt;
  logic [15:0]       r_ded_cnt;
  logic [AW-1:0]     r_ded_addr;

  // -------------------------------------------------------------------------
  // Control
  // -------------------------------------------------------------------------
  dec_t            w_dec;
  logic            w_accept;
  logic            w_rd_accept;
  logic            w_wr_accept;
  logic            w_scrub_chk;
  logic            w_inflight;
  logic            w_scrub_go;
  logic            w_hazard;
  logic [1:0]      w_sec_inc;
  logic [1:0]      w_ded_inc;
  logic            w_re;
  logic [AW-1:0]   w_raddr;
  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [CW_W-1:0] w_wcw;

  // The cycle after a corrected user read holds the writeback slot, so no
  // request is taken in that cycle.
  assign req_ready = (r_state == S_IDLE) && !(r_rsp_valid && r_rsp_sec);

  assign w_accept    = req_valid && req_ready;
  assign w_rd_accept = w_accept && !req_we;
  assign w_wr_accept = w_accept && req_we;

  assign w_dec       = f_decode(r_rd_cw);
  assign w_scrub_chk = (r_state == S_SCRUB_CHK);
  assign w_inflight  = r_rd_vld || r_wb_pend;
  assign w_scrub_go  = (r_state == S_IDLE) && scrub_en &&
                       (r_scrub_cnt == SCRUB_LAST) && !req_valid && !w_inflight;

  // A user write to the address being corrected makes the pending corrected
  // word stale, so the writeback is dropped.
  assign w_hazard    = w_wr_accept && (req_addr == r_rd_addr);

  assign w_sec_inc = {1'b0, r_rd_vld && w_dec.sec} + {1'b0, w_scrub_chk && w_dec.sec};
  assign w_ded_inc = {1'b0, r_rd_vld && w_dec.ded} + {1'b0, w_scrub_chk && w_dec.ded};

  assign w_re    = rst_l && (w_rd_accept || (r_state == S_SCRUB_RD));
  assign w_raddr = (r_state == S_SCRUB_RD) ? r_ptr : req_addr;

  // Write port priority. At most one source is active in any cycle. Only
  // user writes carry the injection mask.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would infer a latch.
    w_we    = 1'b0;
    w_waddr = '0;
    w_wcw   = '0;
    if (r_state == S_INIT) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wcw   = f_encode('0);
    end else if (r_wb_pend) begin
      w_we    = 1'b1;
      w_waddr = r_wb_addr;
      w_wcw   = r_wb_cw;
    end else if (w_scrub_chk && w_dec.sec) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wcw   = w_dec.fixed_cw;
    end else if (w_wr_accept) begin
      w_we    = 1'b1;
      w_waddr = req_addr;
      w_wcw   = f_encode(req_wdata) ^ (inj_en ? inj_mask : '0);
    end
  end

  // -------------------------------------------------------------------------
  // Array and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset. INIT fills it with clean zero codewords
  // after every reset. Writes are gated during reset so a request that
  // arrives together with reset cannot modify the array.
  always_ff @(posedge clk) begin
    if (w_we && rst_l) r_mem[w_waddr] <= w_wcw;
    if (w_re)          r_rd_cw        <= r_mem[w_raddr];
  end

  always_ff @(posedge clk) begin
    if (w_rd_accept) r_rd_addr <= req_addr;
    if (r_rd_vld) begin
      r_wb_addr <= r_rd_addr;
      r_wb_cw   <= w_dec.fixed_cw;
    end
  end

  // -------------------------------------------------------------------------
  // FSM, scrub pointer and interval counter
  // -------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments. Every register
  // then samples values from before the edge, whatever the block order.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= S_INIT;
      r_ptr       <= '0;
      r_scrub_cnt <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_ptr <= r_ptr + 1'b1;
          if (r_ptr == ADDR_LAST) r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (!scrub_en) begin
            r_scrub_cnt <= '0;
          end else if (r_scrub_cnt == SCRUB_LAST) begin
            // Hold at the last count until the port is quiet.
            if (w_scrub_go) begin
              r_state     <= S_SCRUB_RD;
              r_scrub_cnt <= '0;
            end
          end else if (!w_accept) begin
            r_scrub_cnt <= r_scrub_cnt + 1'b1;
          end
        end
        S_SCRUB_RD: r_state <= S_SCRUB_CHK;
        S_SCRUB_CHK: begin
          r_ptr   <= r_ptr + 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read pipeline, response, writeback and error bookkeeping
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_rd_vld    <= 1'b0;
      r_wb_pend   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_sec   <= 1'b0;
      r_rsp_ded   <= 1'b0;
      r_sec_cnt   <= '0;
      r_ded_cnt   <= '0;
      r_ded_addr  <= '0;
    end else begin
      r_rd_vld  <= w_rd_accept;
      r_wb_pend <= r_rd_vld && w_dec.sec && !w_hazard;

      r_rsp_valid <= r_rd_vld;
      r_rsp_rdata <= r_rd_vld ? w_dec.data : '0;
      r_rsp_sec   <= r_rd_vld && w_dec.sec;
      r_rsp_ded   <= r_rd_vld && w_dec.ded;

      r_sec_cnt <= f_sat_add(r_sec_cnt, w_sec_inc);
      r_ded_cnt <= f_sat_add(r_ded_cnt, w_ded_inc);

      if (r_rd_vld && w_dec.ded)         r_ded_addr <= r_rd_addr;
      else if (w_scrub_chk && w_dec.ded) r_ded_addr <= r_ptr;
    end
  end

  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp_rdata;
  assign rsp_single_err = r_rsp_sec;
  assign rsp_double_err = r_rsp_ded;
  assign sec_count      = r_sec_cnt;
  assign ded_count      = r_ded_cnt;
  assign ded_addr       = r_ded_addr;

endmodule

// File: tb/tb_ecc_scrub_mem.sv
// ---------------------------------------------------------------------------
// tb_ecc_scrub_mem
//
// Self-checking bench for ecc_scrub_mem (DATA_W=32, DEPTH=64,
// SCRUB_INTERVAL=4). The expected response of each accepted read is pushed
// to a queue. A negedge monitor pops one entry for every response and
// compares latency, data and flags. Expected error counts are tracked
// alongside the queue.
// ---------------------------------------------------------------------------
module tb_ecc_scrub_mem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int SCRUB_INTERVAL = 4;
  localparam int AW   = 6;
  localparam int CW_W = 39;

  logic              clk;
  logic              rst_l;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              inj_en;
  logic [CW_W-1:0]   inj_mask;
  logic              scrub_en;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_single_err;
  logic              rsp_double_err;
  logic [15:0]       sec_count;
  logic [15:0]       ded_count;
  logic [AW-1:0]     ded_addr;

  ecc_scrub_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .inj_en(inj_en), .inj_mask(inj_mask), .scrub_en(scrub_en),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_single_err(rsp_single_err), .rsp_double_err(rsp_double_err),
    .sec_count(sec_count), .ded_count(ded_count), .ded_addr(ded_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              s;
    logic              d;
    int                due;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   exp_sec  = 0;
  int   exp_ded  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response monitor: every response must match the oldest expectation and
  // arrive exactly two cycles after its accept. Idle response fields stay 0.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l) begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_latency", 64'(cyc), 64'(e.due));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
          check("rsp_single_err", 64'(rsp_single_err), 64'(e.s));
          check("rsp_double_err", 64'(rsp_double_err), 64'(e.d));
        end
      end else begin
        check("rsp_idle_zero", {31'd0, rsp_rdata, rsp_single_err, rsp_double_err}, 64'd0);
      end
    end
  end

  // Present one request at a negedge and hold it until accepted (bounded).
  // Reads push their expectation in the cycle the accept happens.
  task automatic drive(input logic we, input logic [AW-1:0] a,
                       input logic [DATA_W-1:0] wd, input logic [CW_W-1:0] m,
                       input logic [DATA_W-1:0] ed, input logic es, input logic edd,
                       output int waited);
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    inj_en    = (m != '0);
    inj_mask  = m;
    waited    = 0;
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("req_ready_timeout", 64'd0, 64'd1);
    end else if (!we) begin
      e.data = ed; e.s = es; e.d = edd; e.due = cyc + 2;
      sb.push_back(e);
      if (es)  exp_sec++;
      if (edd) exp_ded++;
    end
    @(negedge clk);
    req_valid = 1'b0;
    inj_en    = 1'b0;
    inj_mask  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DATA_W-1:0] d, input logic [CW_W-1:0] m);
    int w;
    drive(1'b1, a, d, m, '0, 1'b0, 1'b0, w);
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DATA_W-1:0] ed, input logic es, input logic edd);
    int w;
    drive(1'b0, a, '0, '0, ed, es, edd, w);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int                n;
    int                w;
    int                b1;
    int                b2;
    logic [CW_W-1:0]   m;
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] rdata_q [12];
    logic [CW_W-1:0]   mask_q  [12];

    rst_l = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; inj_en = 1'b0; inj_mask = '0; scrub_en = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_counts", {32'd0, sec_count, ded_count}, 64'd0);
    check("reset_ded_addr", 64'(ded_addr), 64'd0);

    // T1: ready stays low for exactly DEPTH cycles of INIT.
    rst_l = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("t1_init_cycles", 64'(n), 64'(DEPTH));
    rd(6'd5, 32'h0, 1'b0, 1'b0);
    drain();

    // T2: clean write/read. Latency is checked by the monitor.
    wr(6'd3, 32'hDEADBEEF, '0);
    rd(6'd3, 32'hDEADBEEF, 1'b0, 1'b0);
    drain();

    // T3: single data-bit error is corrected and written back.
    wr(6'd4, 32'h12345678, 39'(1) << 7);
    rd(6'd4, 32'h12345678, 1'b1, 1'b0);
    drain();
    check("t3_sec_count", 64'(sec_count), 64'd1);
    rd(6'd4, 32'h12345678, 1'b0, 1'b0);
    drain();

    // T4: data bit 0 plus the parity bit gives an uncorrectable error.
    wr(6'd9, 32'hA5A5A5A5, (39'(1) << 0) | (39'(1) << 38));
    rd(6'd9, 32'hA5A5A5A4, 1'b0, 1'b1);
    drain();
    check("t4_ded_count", 64'(ded_count), 64'd1);
    check("t4_ded_addr", 64'(ded_addr), 64'd9);
    rd(6'd9, 32'hA5A5A5A4, 1'b0, 1'b1);
    drain();
    check("t4_ded_persist", 64'(ded_count), 64'd2);

    // T5: the scrubber finds and repairs a single error at address 0.
    wr(6'd0, 32'hCAFEF00D, 39'(1) << 3);
    scrub_en = 1'b1;
    n = 0;
    while (sec_count != 16'(exp_sec + 1) && n < 8) begin
      @(negedge clk);
      n++;
    end
    scrub_en = 1'b0;
    check("t5_scrub_sec", 64'(sec_count), 64'(exp_sec + 1));
    exp_sec++;
    repeat (2) @(negedge clk);
    rd(6'd0, 32'hCAFEF00D, 1'b0, 1'b0);
    drain();

    // T6: a write to the same address in the next cycle cancels the writeback.
    wr(6'd2, 32'h0BADF00D, 39'(1) << 35);
    rd(6'd2, 32'h0BADF00D, 1'b1, 1'b0);
    drive(1'b1, 6'd2, 32'h0, '0, '0, 1'b0, 1'b0, w);
    check("t6_write_next_cycle", 64'(w), 64'd0);
    drain();
    rd(6'd2, 32'h0, 1'b0, 1'b0);
    drain();

    // Mixed traffic: clean, single (any bit) and double (any two bits),
    // then back-to-back reads.
    for (int j = 0; j < 12; j++) begin
      d = $urandom;
      m = '0;
      b1 = $urandom_range(0, CW_W - 1);
      b2 = (b1 + 1 + $urandom_range(0, CW_W - 2)) % CW_W;
      if (j % 3 >= 1) m[b1] = 1'b1;
      if (j % 3 == 2) m[b2] = 1'b1;
      rdata_q[j] = (j % 3 == 2) ? (d ^ m[DATA_W-1:0]) : d;
      mask_q[j]  = m;
      wr(6'(16 + 3 * j), d, m);
    end
    for (int j = 0; j < 12; j++) begin
      rd(6'(16 + 3 * j), rdata_q[j], (j % 3 == 1), (j % 3 == 2));
    end
    drain();
    check("mix_sec_count", 64'(sec_count), 64'(exp_sec));
    check("mix_ded_count", 64'(ded_count), 64'(exp_ded));
    check("mix_ded_addr", 64'(ded_addr), 64'(16 + 3 * 11));

    // Reset after traffic clears counters and restarts INIT.
    rst_l = 1'b0;
    @(negedge clk);
    check("rst2_counts", {32'd0, sec_count, ded_count}, 64'd0);
    check("rst2_ded_addr", 64'(ded_addr), 64'd0);
    check("rst2_req_ready", 64'(req_ready), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
